// File: rtl/laser_pkg.sv
// laser_pkg: constants, state encoding and point type shared by the laser solver and its checker.
package laser_pkg;
  localparam int NPTS = 40;
  localparam int CW   = 4;
  localparam int HW   = 6;
  localparam int PW   = $clog2(NPTS);
  localparam logic [2*CW:0] RADIUS_SQ = (2*CW+1)'(16);
  typedef enum logic [1:0] {LOAD, READY, EVAL, OUT} state_t;
  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pt_t;
  function automatic logic [2*CW-1:0] sq(input logic [CW-1:0] a);
    return {{CW{1'b0}}, a} * {{CW{1'b0}}, a};
  endfunction
endpackage

// File: rtl/laser_in_circle.sv
// laser_in_circle: flags whether point (px,py) lies within the inclusive radius of centre (cx,cy).
module laser_in_circle
  import laser_pkg::*;
(
  input  logic [CW-1:0] px,
  input  logic [CW-1:0] py,
  input  logic [CW-1:0] cx,
  input  logic [CW-1:0] cy,
  output logic          in
);
  logic [CW-1:0] dx, dy;
  logic [2*CW:0] d2;
  assign dx = px >= cx ? px - cx : cx - px;
  assign dy = py >= cy ? py - cy : cy - py;
  assign d2 = {1'b0, sq(dx)} + {1'b0, sq(dy)};
  assign in = d2 <= RADIUS_SQ;
endmodule

// File: rtl/laser_cover_eval.sv
// laser_cover_eval: captures a frame of points, then on each DONE_IN rise re-scores the two
// solver centres one point per cycle and reports per-centre and combined coverage counts.
module laser_cover_eval
  import laser_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  input  logic          LOAD_EN,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  input  logic          DONE_IN,
  input  logic [CW-1:0] C1X,
  input  logic [CW-1:0] C1Y,
  input  logic [CW-1:0] C2X,
  input  logic [CW-1:0] C2Y,
  output logic [HW-1:0] HITS,
  output logic [HW-1:0] HIT1,
  output logic [HW-1:0] HIT2,
  output logic          VALID,
  output logic          BUSY,
  output logic          ERR
);
  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          loaded_q, loaded_d, done_d_q;
  pt_t           c1_q, c1_d, c2_q, c2_d;
  logic [HW-1:0] hits_q, hits_d, hit1_q, hit1_d, hit2_q, hit2_d;
  logic          valid_q, valid_d, err_q, err_d;
  pt_t           pts_q [NPTS];
  pt_t           cur;
  logic          rise, in1, in2, wr_en;
  assign rise  = DONE_IN & ~done_d_q;
  assign wr_en = state_q == LOAD && LOAD_EN;
  assign cur   = pts_q[rd_ptr_q];
  laser_in_circle u_in1 (.px(cur.x), .py(cur.y), .cx(c1_q.x), .cy(c1_q.y), .in(in1));
  laser_in_circle u_in2 (.px(cur.x), .py(cur.y), .cx(c2_q.x), .cy(c2_q.y), .in(in2));
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    loaded_d = loaded_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    hits_d   = hits_q;
    hit1_d   = hit1_q;
    hit2_d   = hit2_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      LOAD: begin
        err_d = rise;
        if (LOAD_EN) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (wr_ptr_q == PW'(NPTS - 1)) begin
            state_d  = READY;
            loaded_d = 1'b1;
          end
        end
      end
      READY: begin
        if (rise && loaded_q) begin
          c1_d     = '{x: C1X, y: C1Y};
          c2_d     = '{x: C2X, y: C2Y};
          hits_d   = '0;
          hit1_d   = '0;
          hit2_d   = '0;
          rd_ptr_d = '0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        hit1_d   = hit1_q + HW'(in1);
        hit2_d   = hit2_q + HW'(in2);
        hits_d   = hits_q + HW'(in1 | in2);
        rd_ptr_d = rd_ptr_q + PW'(1);
        state_d  = rd_ptr_q == PW'(NPTS - 1) ? OUT : EVAL;
      end
      OUT: begin
        valid_d = 1'b1;
        state_d = READY;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= LOAD;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      loaded_q <= 1'b0;
      done_d_q <= 1'b0;
      c1_q     <= '0;
      c2_q     <= '0;
      hits_q   <= '0;
      hit1_q   <= '0;
      hit2_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      loaded_q <= loaded_d;
      done_d_q <= DONE_IN;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      hits_q   <= hits_d;
      hit1_q   <= hit1_d;
      hit2_q   <= hit2_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end
  // The store needs no reset: a reset rewinds wr_ptr, so stale points are never read.
  always_ff @(posedge CLK) begin
    if (wr_en) pts_q[wr_ptr_q] <= '{x: X, y: Y};
  end
  assign HITS  = hits_q;
  assign HIT1  = hit1_q;
  assign HIT2  = hit2_q;
  assign VALID = valid_q;
  assign BUSY  = state_q == EVAL;
  assign ERR   = err_q;
endmodule

// File: tb/tb_laser_cover_eval.sv
// tb_laser_cover_eval: directed frames with hand-computed coverage counts, checked by a scoreboard monitor.
module tb_laser_cover_eval;
  import laser_pkg::*;
  typedef struct {int hits; int h1; int h2;} exp_t;
  logic CLK = 0, RST = 1, LOAD_EN = 0, DONE_IN = 0;
  logic [CW-1:0] X = 0, Y = 0, C1X = 0, C1Y = 0, C2X = 0, C2Y = 0;
  logic [HW-1:0] HITS, HIT1, HIT2;
  logic VALID, BUSY, ERR;
  logic [CW-1:0] ax [NPTS], ay [NPTS];
  exp_t sb [$];
  exp_t e;
  int nchk = 0, nfail = 0, err_cnt = 0, val_cnt = 0;
  always #5 CLK = ~CLK;
  laser_cover_eval dut (
    .CLK(CLK), .RST(RST), .LOAD_EN(LOAD_EN), .X(X), .Y(Y), .DONE_IN(DONE_IN),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .HITS(HITS), .HIT1(HIT1), .HIT2(HIT2), .VALID(VALID), .BUSY(BUSY), .ERR(ERR)
  );
  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge CLK) begin
    if (ERR) err_cnt++;
    if (VALID) begin
      val_cnt++;
      if (sb.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        e = sb.pop_front();
        chk("sb_hits", int'(HITS), e.hits);
        chk("sb_hit1", int'(HIT1), e.h1);
        chk("sb_hit2", int'(HIT2), e.h2);
      end
    end
  end
  task automatic fill(input logic [CW-1:0] x0, y0, x1, y1);
    for (int i = 0; i < NPTS; i++) begin
      ax[i] = i % 2 ? x1 : x0;
      ay[i] = i % 2 ? y1 : y0;
    end
  endtask
  task automatic load(input int a, input int b);
    for (int i = a; i < b; i++) begin
      @(negedge CLK);
      LOAD_EN = 1; X = ax[i]; Y = ay[i];
    end
    @(negedge CLK);
    LOAD_EN = 0;
  endtask
  task automatic do_reset();
    @(negedge CLK);
    RST = 1;
    repeat (2) @(negedge CLK);
    RST = 0;
  endtask
  task automatic eval(input string nm, input logic [CW-1:0] c1x, c1y, c2x, c2y,
                      input int hold, input bit retrig, input int h, h1, h2);
    int cnt;
    @(negedge CLK);
    C1X = c1x; C1Y = c1y; C2X = c2x; C2Y = c2y;
    DONE_IN = 1;
    sb.push_back('{h, h1, h2});
    cnt = 0;
    while (cnt < 100) begin
      @(posedge CLK);
      #1;
      if (VALID) break;
      cnt++;
      if (cnt == hold) DONE_IN = 0;
      if (retrig && cnt == 10) DONE_IN = 1;
      if (retrig && cnt == 12) DONE_IN = 0;
      if (cnt == 20) chk({nm, "_busy"}, int'(BUSY), 1);
    end
    DONE_IN = 0;
    chk({nm, "_latency"}, cnt, 41);
    repeat (3) @(posedge CLK);
    #1;
    chk({nm, "_hold_hits"}, int'(HITS), h);
    chk({nm, "_idle"}, int'(BUSY), 0);
  endtask
  initial begin
    int e0, cnt;
    repeat (2) @(negedge CLK);
    RST = 0;
    chk("rst_hits", int'(HITS), 0);
    chk("rst_hit1", int'(HIT1), 0);
    chk("rst_hit2", int'(HIT2), 0);
    chk("rst_valid", int'(VALID), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_err", int'(ERR), 0);
    fill(8, 8, 8, 8);
    load(0, NPTS);
    eval("center", 8, 8, 0, 0, 1, 0, 40, 40, 0);
    eval("second", 0, 0, 8, 12, 5, 1, 40, 0, 40);
    do_reset();
    fill(12, 8, 11, 11);
    load(0, NPTS);
    eval("boundary", 8, 8, 0, 15, 1, 0, 20, 20, 0);
    do_reset();
    fill(4, 4, 4, 4);
    load(0, NPTS);
    eval("overlap", 4, 4, 6, 6, 1, 0, 40, 40, 40);
    do_reset();
    load(0, 10);
    e0 = err_cnt;
    @(negedge CLK);
    DONE_IN = 1;
    repeat (3) @(negedge CLK);
    DONE_IN = 0;
    @(negedge CLK);
    chk("early_err_pulses", err_cnt - e0, 1);
    chk("early_no_busy", int'(BUSY), 0);
    load(10, NPTS);
    eval("late", 4, 4, 15, 15, 1, 0, 40, 40, 0);
    @(negedge CLK);
    C1X = 8; C1Y = 8; C2X = 8; C2Y = 8;
    DONE_IN = 1;
    cnt = 0;
    while (cnt < 20) begin
      @(posedge CLK);
      #1;
      cnt++;
      if (cnt == 2) DONE_IN = 0;
    end
    chk("abort_busy", int'(BUSY), 1);
    RST = 1;
    @(posedge CLK);
    #1;
    RST = 0;
    chk("abort_hits", int'(HITS), 0);
    chk("abort_hit1", int'(HIT1), 0);
    chk("abort_busy_clr", int'(BUSY), 0);
    e0 = err_cnt;
    @(negedge CLK);
    DONE_IN = 1;
    @(negedge CLK);
    DONE_IN = 0;
    @(negedge CLK);
    chk("abort_in_load", err_cnt - e0, 1);
    fill(15, 15, 15, 15);
    load(0, NPTS);
    eval("exact_sq", 0, 0, 15, 15, 1, 0, 40, 0, 40);
    repeat (5) @(negedge CLK);
    chk("valid_total", val_cnt, 6);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
